// File: rtl/cntr8_ctrl.sv
// cntr8_ctrl: debounced button/switch front end issuing load strobes and count direction.
// Define CNTR8_CTRL_SYNC_EN to add 2-flop synchronizers on btn_load, btn_dir and sw.
module cntr8_ctrl #(
    parameter int DB_CYCLES = 4,
    parameter int DW        = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          btn_load,
    input  logic          btn_dir,
    input  logic [DW-1:0] sw,
    output logic          load,
    output logic          inc,
    output logic [DW-1:0] d_in,
    output logic [1:0]    o_lstate,
    output logic [3:0]    o_cmd_cnt
);
    localparam int CW = $clog2(DB_CYCLES);

    typedef enum logic [1:0] {L_IDLE = 2'd0, L_PULSE = 2'd1, L_WAIT = 2'd2} lstate_t;

    logic [1:0]    raw;
    logic [DW-1:0] sw_s;

`ifdef CNTR8_CTRL_SYNC_EN
    logic [1:0]    s_load, s_dir;
    logic [DW-1:0] s_sw1, s_sw2;
    always_ff @(posedge clk) begin
        if (reset) begin
            s_load <= '0;
            s_dir  <= '0;
            s_sw1  <= '0;
            s_sw2  <= '0;
        end else begin
            s_load <= {s_load[0], btn_load};
            s_dir  <= {s_dir[0], btn_dir};
            s_sw1  <= sw;
            s_sw2  <= s_sw1;
        end
    end
    assign raw  = {s_dir[1], s_load[1]};
    assign sw_s = s_sw2;
`else
    assign raw  = {btn_dir, btn_load};
    assign sw_s = sw;
`endif

    // bit 0 = load button, bit 1 = direction button
    logic [1:0]    db, db_q, rise;
    logic [CW-1:0] c [2];

    always_ff @(posedge clk) begin
        if (reset) begin
            db   <= '0;
            db_q <= '0;
            c[0] <= '0;
            c[1] <= '0;
        end else begin
            db_q <= db;
            for (int i = 0; i < 2; i++) begin
                if (raw[i] == db[i]) c[i] <= '0;
                else if (c[i] == CW'(DB_CYCLES - 1)) begin
                    db[i] <= raw[i];
                    c[i]  <= '0;
                end else c[i] <= c[i] + 1'b1;
            end
        end
    end

    assign rise = db & ~db_q;

    lstate_t state, next_state;
    logic    capture;

    always_comb begin
        capture    = (state == L_IDLE) && rise[0];
        next_state = capture ? L_PULSE :
                     (state == L_PULSE) ? L_WAIT :
                     (state == L_WAIT && db[0]) ? L_WAIT : L_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= L_IDLE;
            inc       <= 1'b1;
            d_in      <= '0;
            o_cmd_cnt <= '0;
        end else begin
            state     <= next_state;
            inc       <= inc ^ rise[1];
            d_in      <= capture ? sw_s : d_in;
            o_cmd_cnt <= o_cmd_cnt + 4'(capture) + 4'(rise[1]);
        end
    end

    assign load     = (state == L_PULSE);
    assign o_lstate = state;
endmodule

// File: tb/tb_cntr8_ctrl.sv
// tb_cntr8_ctrl: directed self-checking bench for cntr8_ctrl (default and synchronized builds).
module tb_cntr8_ctrl;
    localparam int DB = 4;
`ifdef CNTR8_CTRL_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif
    localparam int LAT = DB + 1 + SL;

    logic       clk = 0, reset = 1, btn_load = 0, btn_dir = 0;
    logic [7:0] sw = 0;
    logic       load, inc;
    logic [7:0] d_in;
    logic [1:0] o_lstate;
    logic [3:0] o_cmd_cnt;
    int         checks = 0, failures = 0;

    cntr8_ctrl #(.DB_CYCLES(DB), .DW(8)) dut (
        .clk(clk), .reset(reset), .btn_load(btn_load), .btn_dir(btn_dir), .sw(sw),
        .load(load), .inc(inc), .d_in(d_in), .o_lstate(o_lstate), .o_cmd_cnt(o_cmd_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run(input int n, output int pulses, output int first);
        pulses = 0;
        first  = -1;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (load) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1;
        btn_load = 1;
        tick(3);
        checks++; if (load !== 1'b0) begin failures++; $display("FAIL reset_load got=%0b exp=0", load); end
        checks++; if (inc !== 1'b1) begin failures++; $display("FAIL reset_inc got=%0b exp=1", inc); end
        checks++; if (d_in !== 8'h00) begin failures++; $display("FAIL reset_d_in got=%0h exp=00", d_in); end
        checks++; if (o_cmd_cnt !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", o_cmd_cnt); end
        checks++; if (o_lstate !== 2'd0) begin failures++; $display("FAIL reset_lstate got=%0d exp=0", o_lstate); end
        btn_load = 0;
        reset = 0;
        tick(2);
    endtask

    task automatic test_clean_load;
        int pulses = 0, first = -1;
        logic [1:0] st_pre = 2'bxx, st_lat = 2'bxx, st_post = 2'bxx;
        sw = 8'hA5;
        btn_load = 1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (load) begin
                pulses++;
                if (first < 0) first = i;
            end
            if (i == LAT - 1) st_pre = o_lstate;
            if (i == LAT) st_lat = o_lstate;
            if (i == LAT + 1) st_post = o_lstate;
            if (i == LAT + 1) sw = 8'h3C;
        end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL clean_pulses got=%0d exp=1", pulses); end
        checks++; if (first !== LAT) begin failures++; $display("FAIL clean_latency got=%0d exp=%0d", first, LAT); end
        checks++; if (st_pre !== 2'd0) begin failures++; $display("FAIL clean_state_pre got=%0d exp=0", st_pre); end
        checks++; if (st_lat !== 2'd1) begin failures++; $display("FAIL clean_state_pulse got=%0d exp=1", st_lat); end
        checks++; if (st_post !== 2'd2) begin failures++; $display("FAIL clean_state_wait got=%0d exp=2", st_post); end
        checks++; if (d_in !== 8'hA5) begin failures++; $display("FAIL clean_d_in got=%0h exp=a5", d_in); end
        checks++; if (o_cmd_cnt !== 4'd1) begin failures++; $display("FAIL clean_cnt got=%0d exp=1", o_cmd_cnt); end
        checks++; if (o_lstate !== 2'd2) begin failures++; $display("FAIL clean_held_state got=%0d exp=2", o_lstate); end
        btn_load = 0;
        tick(DB + SL + 2);
        checks++; if (o_lstate !== 2'd0) begin failures++; $display("FAIL clean_release_state got=%0d exp=0", o_lstate); end
    endtask

    task automatic test_glitch;
        int pulses, first;
        sw = 8'h11;
        btn_load = 1;
        tick(DB - 1);
        btn_load = 0;
        run(15, pulses, first);
        checks++; if (pulses !== 0) begin failures++; $display("FAIL glitch_pulses got=%0d exp=0", pulses); end
        checks++; if (d_in !== 8'hA5) begin failures++; $display("FAIL glitch_d_in got=%0h exp=a5", d_in); end
        checks++; if (o_cmd_cnt !== 4'd1) begin failures++; $display("FAIL glitch_cnt got=%0d exp=1", o_cmd_cnt); end
    endtask

    task automatic test_direction;
        logic exp_inc;
        exp_inc = 1'b1;
        for (int p = 0; p < 2; p++) begin
            btn_dir = 1;
            for (int i = 1; i <= LAT + 3; i++) begin
                tick();
                if (i == LAT - 1) begin
                    checks++; if (inc !== exp_inc) begin failures++; $display("FAIL dir_early p=%0d got=%0b exp=%0b", p, inc, exp_inc); end
                end
                if (i == LAT) begin
                    exp_inc = ~exp_inc;
                    checks++; if (inc !== exp_inc) begin failures++; $display("FAIL dir_toggle p=%0d got=%0b exp=%0b", p, inc, exp_inc); end
                end
            end
            btn_dir = 0;
            tick(DB + SL + 3);
            checks++; if (load !== 1'b0) begin failures++; $display("FAIL dir_no_load p=%0d got=%0b exp=0", p, load); end
        end
        checks++; if (inc !== 1'b1) begin failures++; $display("FAIL dir_final_inc got=%0b exp=1", inc); end
        checks++; if (o_cmd_cnt !== 4'd3) begin failures++; $display("FAIL dir_cnt got=%0d exp=3", o_cmd_cnt); end
    endtask

    task automatic test_simultaneous;
        logic       exp_inc;
        logic [3:0] exp_cnt;
        reset = 1;
        tick(2);
        reset = 0;
        tick(1);
        exp_inc = 1'b1;
        exp_cnt = 4'd0;
        for (int p = 0; p < 8; p++) begin
            btn_load = 1;
            btn_dir = 1;
            sw = 8'(p + 8'h40);
            for (int i = 1; i <= LAT + 2; i++) begin
                tick();
                if (i == LAT) begin
                    exp_inc = ~exp_inc;
                    checks++; if (load !== 1'b1) begin failures++; $display("FAIL sim_load p=%0d got=%0b exp=1", p, load); end
                    checks++; if (inc !== exp_inc) begin failures++; $display("FAIL sim_inc p=%0d got=%0b exp=%0b", p, inc, exp_inc); end
                end
            end
            btn_load = 0;
            btn_dir = 0;
            tick(DB + SL + 3);
            exp_cnt = exp_cnt + 4'd2;
            checks++; if (o_cmd_cnt !== exp_cnt) begin failures++; $display("FAIL sim_cnt p=%0d got=%0d exp=%0d", p, o_cmd_cnt, exp_cnt); end
        end
        checks++; if (o_cmd_cnt !== 4'd0) begin failures++; $display("FAIL sim_wrap got=%0d exp=0", o_cmd_cnt); end
        checks++; if (inc !== 1'b1) begin failures++; $display("FAIL sim_final_inc got=%0b exp=1", inc); end
        checks++; if (d_in !== 8'h47) begin failures++; $display("FAIL sim_d_in got=%0h exp=47", d_in); end
    endtask

    task automatic test_reset_mid_wait;
        int pulses, first;
        sw = 8'h77;
        btn_load = 1;
        tick(LAT + 2);
        checks++; if (o_lstate !== 2'd2) begin failures++; $display("FAIL rw_in_wait got=%0d exp=2", o_lstate); end
        reset = 1;
        tick(2);
        reset = 0;
        btn_load = 0;
        tick(1);
        checks++; if (o_lstate !== 2'd0) begin failures++; $display("FAIL rw_idle got=%0d exp=0", o_lstate); end
        checks++; if (d_in !== 8'h00) begin failures++; $display("FAIL rw_d_in_reset got=%0h exp=00", d_in); end
        run(10, pulses, first);
        checks++; if (pulses !== 0) begin failures++; $display("FAIL rw_quiet got=%0d exp=0", pulses); end
        sw = 8'h5A;
        btn_load = 1;
        run(LAT + 8, pulses, first);
        checks++; if (pulses !== 1) begin failures++; $display("FAIL rw_pulses got=%0d exp=1", pulses); end
        checks++; if (first !== LAT) begin failures++; $display("FAIL rw_latency got=%0d exp=%0d", first, LAT); end
        checks++; if (d_in !== 8'h5A) begin failures++; $display("FAIL rw_d_in got=%0h exp=5a", d_in); end
        checks++; if (o_cmd_cnt !== 4'd1) begin failures++; $display("FAIL rw_cnt got=%0d exp=1", o_cmd_cnt); end
        btn_load = 0;
        tick(DB + SL + 3);
    endtask

    initial begin
        test_reset();
        test_clean_load();
        test_glitch();
        test_direction();
        test_simultaneous();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
